// File: rtl/pipe_forward_datapath.sv
// Operand forwarding muxes plus ID/EX, EX/MEM and MEM/WB stage registers of the 5-stage core.
// ID to WB is three register stages; stalls and bubbles come from the hazard unit's enable/flush controls.
module pipe_forward_datapath #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            reg_DE_EN,
   input  logic            reg_DE_flush,
   input  logic            reg_EM_EN,
   input  logic            reg_EM_flush,
   input  logic            reg_MW_EN,
   input  logic [1:0]      forward_ctrl_A,
   input  logic [1:0]      forward_ctrl_B,
   input  logic            forward_ctrl_ls,
   input  logic [XLEN-1:0] rs1_data_ID,
   input  logic [XLEN-1:0] rs2_data_ID,
   input  logic [REGW-1:0] rd_ID,
   input  logic            regwrite_ID,
   input  logic            memread_ID,
   input  logic            memwrite_ID,
   input  logic [XLEN-1:0] alu_out_EXE,
   input  logic [XLEN-1:0] mem_rdata_MEM,
   output logic [XLEN-1:0] rs1_fwd_ID,
   output logic [XLEN-1:0] rs2_fwd_ID,
   output logic [XLEN-1:0] rs1_EXE,
   output logic [XLEN-1:0] rs2_EXE_data,
   output logic [REGW-1:0] rd_EXE,
   output logic [REGW-1:0] rd_MEM,
   output logic [REGW-1:0] rs2_EXE,
   input  logic [REGW-1:0] rs2_ID,
   output logic [XLEN-1:0] alu_out_MEM,
   output logic [XLEN-1:0] mem_wdata_MEM,
   output logic            mem_we_MEM,
   output logic            mem_re_MEM,
   output logic            wb_we,
   output logic [REGW-1:0] wb_rd,
   output logic [XLEN-1:0] wb_data
);

   // ID/EX
   logic [XLEN-1:0] rs1_ex_d, rs1_ex_q, rs2_ex_d, rs2_ex_q;
   logic [REGW-1:0] rd_ex_d, rd_ex_q, rs2_idx_ex_d, rs2_idx_ex_q;
   logic            regwrite_ex_d, regwrite_ex_q, memread_ex_d, memread_ex_q;
   logic            memwrite_ex_d, memwrite_ex_q;
   // EX/MEM
   logic [XLEN-1:0] alu_mem_d, alu_mem_q, rs2_mem_d, rs2_mem_q;
   logic [REGW-1:0] rd_mem_d, rd_mem_q;
   logic            regwrite_mem_d, regwrite_mem_q, memread_mem_d, memread_mem_q;
   logic            memwrite_mem_d, memwrite_mem_q, ls_sel_d, ls_sel_q;
   // MEM/WB
   logic [XLEN-1:0] alu_wb_d, alu_wb_q, ldata_wb_d, ldata_wb_q;
   logic [REGW-1:0] rd_wb_d, rd_wb_q;
   logic            regwrite_wb_d, regwrite_wb_q, memtoreg_wb_d, memtoreg_wb_q;

   always_comb begin
      unique case (forward_ctrl_A)
         2'b01:   rs1_fwd_ID = alu_out_EXE;
         2'b10:   rs1_fwd_ID = alu_mem_q;
         2'b11:   rs1_fwd_ID = mem_rdata_MEM;
         default: rs1_fwd_ID = rs1_data_ID;
      endcase
      unique case (forward_ctrl_B)
         2'b01:   rs2_fwd_ID = alu_out_EXE;
         2'b10:   rs2_fwd_ID = alu_mem_q;
         2'b11:   rs2_fwd_ID = mem_rdata_MEM;
         default: rs2_fwd_ID = rs2_data_ID;
      endcase
   end

   always_comb begin
      rs1_ex_d      = rs1_ex_q;
      rs2_ex_d      = rs2_ex_q;
      rd_ex_d       = rd_ex_q;
      rs2_idx_ex_d  = rs2_idx_ex_q;
      regwrite_ex_d = regwrite_ex_q;
      memread_ex_d  = memread_ex_q;
      memwrite_ex_d = memwrite_ex_q;
      if (reg_DE_flush) begin
         rs1_ex_d      = '0;
         rs2_ex_d      = '0;
         rd_ex_d       = '0;
         rs2_idx_ex_d  = '0;
         regwrite_ex_d = 1'b0;
         memread_ex_d  = 1'b0;
         memwrite_ex_d = 1'b0;
      end else if (reg_DE_EN) begin
         rs1_ex_d      = rs1_fwd_ID;
         rs2_ex_d      = rs2_fwd_ID;
         rd_ex_d       = rd_ID;
         rs2_idx_ex_d  = rs2_ID;
         regwrite_ex_d = regwrite_ID;
         memread_ex_d  = memread_ID;
         memwrite_ex_d = memwrite_ID;
      end
   end

   always_comb begin
      alu_mem_d      = alu_mem_q;
      rs2_mem_d      = rs2_mem_q;
      rd_mem_d       = rd_mem_q;
      regwrite_mem_d = regwrite_mem_q;
      memread_mem_d  = memread_mem_q;
      memwrite_mem_d = memwrite_mem_q;
      ls_sel_d       = ls_sel_q;
      if (reg_EM_flush) begin
         alu_mem_d      = '0;
         rs2_mem_d      = '0;
         rd_mem_d       = '0;
         regwrite_mem_d = 1'b0;
         memread_mem_d  = 1'b0;
         memwrite_mem_d = 1'b0;
         ls_sel_d       = 1'b0;
      end else if (reg_EM_EN) begin
         alu_mem_d      = alu_out_EXE;
         rs2_mem_d      = rs2_ex_q;
         rd_mem_d       = rd_ex_q;
         regwrite_mem_d = regwrite_ex_q;
         memread_mem_d  = memread_ex_q;
         memwrite_mem_d = memwrite_ex_q;
         ls_sel_d       = forward_ctrl_ls;
      end
   end

   always_comb begin
      alu_wb_d      = alu_wb_q;
      ldata_wb_d    = ldata_wb_q;
      rd_wb_d       = rd_wb_q;
      regwrite_wb_d = regwrite_wb_q;
      memtoreg_wb_d = memtoreg_wb_q;
      if (reg_MW_EN) begin
         alu_wb_d      = alu_mem_q;
         ldata_wb_d    = mem_rdata_MEM;
         rd_wb_d       = rd_mem_q;
         regwrite_wb_d = regwrite_mem_q;
         memtoreg_wb_d = memread_mem_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rs1_ex_q       <= '0;
         rs2_ex_q       <= '0;
         rd_ex_q        <= '0;
         rs2_idx_ex_q   <= '0;
         regwrite_ex_q  <= 1'b0;
         memread_ex_q   <= 1'b0;
         memwrite_ex_q  <= 1'b0;
         alu_mem_q      <= '0;
         rs2_mem_q      <= '0;
         rd_mem_q       <= '0;
         regwrite_mem_q <= 1'b0;
         memread_mem_q  <= 1'b0;
         memwrite_mem_q <= 1'b0;
         ls_sel_q       <= 1'b0;
         alu_wb_q       <= '0;
         ldata_wb_q     <= '0;
         rd_wb_q        <= '0;
         regwrite_wb_q  <= 1'b0;
         memtoreg_wb_q  <= 1'b0;
      end else begin
         rs1_ex_q       <= rs1_ex_d;
         rs2_ex_q       <= rs2_ex_d;
         rd_ex_q        <= rd_ex_d;
         rs2_idx_ex_q   <= rs2_idx_ex_d;
         regwrite_ex_q  <= regwrite_ex_d;
         memread_ex_q   <= memread_ex_d;
         memwrite_ex_q  <= memwrite_ex_d;
         alu_mem_q      <= alu_mem_d;
         rs2_mem_q      <= rs2_mem_d;
         rd_mem_q       <= rd_mem_d;
         regwrite_mem_q <= regwrite_mem_d;
         memread_mem_q  <= memread_mem_d;
         memwrite_mem_q <= memwrite_mem_d;
         ls_sel_q       <= ls_sel_d;
         alu_wb_q       <= alu_wb_d;
         ldata_wb_q     <= ldata_wb_d;
         rd_wb_q        <= rd_wb_d;
         regwrite_wb_q  <= regwrite_wb_d;
         memtoreg_wb_q  <= memtoreg_wb_d;
      end
   end

   assign rs1_EXE      = rs1_ex_q;
   assign rs2_EXE_data = rs2_ex_q;
   assign rd_EXE       = rd_ex_q;
   assign rs2_EXE      = rs2_idx_ex_q;
   assign rd_MEM       = rd_mem_q;
   assign alu_out_MEM  = alu_mem_q;
   assign mem_we_MEM   = memwrite_mem_q;
   assign mem_re_MEM   = memread_mem_q;
   // The producing load has already moved to WB when its dependent store reaches MEM.
   assign mem_wdata_MEM = ls_sel_q ? ldata_wb_q : rs2_mem_q;

   assign wb_rd   = rd_wb_q;
   assign wb_data = memtoreg_wb_q ? ldata_wb_q : alu_wb_q;
   assign wb_we   = regwrite_wb_q && (rd_wb_q != '0);

endmodule

// File: doc/pipe_forward_datapath.md
Name: pipe_forward_datapath

Overview:
- Datapath counterpart of the pipeline hazard detection unit.
- Consumes its enable, flush and forward-select controls.
- Holds the ID/EX, EX/MEM and MEM/WB operand and result registers of the 5-stage RISC-V core.
- Produces the forwarded ID-stage operands, the MEM-stage store data (with load-to-store forwarding) and the WB-stage write-back bus.

Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- reg_DE_EN  in  1  ID/EX register load enable
- reg_DE_flush  in  1  ID/EX bubble insert
- reg_EM_EN  in  1  EX/MEM register load enable
- reg_EM_flush  in  1  EX/MEM bubble insert
- reg_MW_EN  in  1  MEM/WB register load enable
- forward_ctrl_A  in  2  rs1 operand select in ID
- forward_ctrl_B  in  2  rs2 operand select in ID
- forward_ctrl_ls  in  1  store in EX needs data from the load in MEM
- rs1_data_ID  in  XLEN  register-file read port 1
- rs2_data_ID  in  XLEN  register-file read port 2
- rd_ID  in  REGW  destination index
- regwrite_ID  in  1  writes rd
- memread_ID  in  1  load
- memwrite_ID  in  1  store
- alu_out_EXE  in  XLEN  combinational ALU result of the EX instruction
- mem_rdata_MEM  in  XLEN  data-memory read data for the MEM instruction
- rs1_fwd_ID  out  XLEN  forwarded operand A to ID/EX
- rs2_fwd_ID  out  XLEN  forwarded operand B to ID/EX
- rs1_EXE  out  XLEN  latched operand A
- rs2_EXE_data  out  XLEN  latched operand B
- rd_EXE  out  REGW  EX destination, to hazard unit
- rd_MEM  out  REGW  MEM destination, to hazard unit
- rs2_EXE  out  REGW  EX rs2 index, to hazard unit
- rs2_ID  in  REGW  rs2 index in ID
- alu_out_MEM  out  XLEN  latched ALU result, data-memory address
- mem_wdata_MEM  out  XLEN  store data to memory
- mem_we_MEM  out  1  memory write strobe
- mem_re_MEM  out  1  memory read strobe
- wb_we  out  1  register-file write enable
- wb_rd  out  REGW  register-file write index
- wb_data  out  XLEN  register-file write data

Behaviour:

Reset:
- rst high at a clock edge clears every stage register to zero: all data, indices, control flags and the ls flag.
- Outputs are therefore 0 one cycle after reset.
- Reset has priority over all enables and flushes, including mid-stall.

Forward muxes (combinational, ID):
- 00 selects the register-file value.
- 01 selects alu_out_EXE.
- 10 selects alu_out_MEM.
- 11 selects mem_rdata_MEM.
- The A and B selects are independent.

ID/EX register:
- If reg_DE_flush: load a bubble. Bubble = data 0, rd 0, rs2 index 0, regwrite/memread/memwrite 0.
- Else if reg_DE_EN: load rs1_fwd_ID, rs2_fwd_ID, rd_ID, rs2_ID and the control flags.
- Else: hold.
- Flush wins over EN=0.

EX/MEM register:
- Same priority rules using reg_EM_flush and reg_EM_EN.
- Captures alu_out_EXE, rs2_EXE_data, rd, the control flags, and ls_sel <= forward_ctrl_ls.
- A flush clears ls_sel.

MEM/WB register:
- If reg_MW_EN: capture alu_out_MEM, mem_rdata_MEM, rd, regwrite and memread (memtoreg).
- Else: hold.

Load-to-store forwarding:
- mem_wdata_MEM = ls_sel ? load data held in MEM/WB : rs2 data held in EX/MEM.
- The select is a one-cycle-delayed use of forward_ctrl_ls.
- The load has moved to WB when the store reaches MEM.

Write-back:
- wb_data = memtoreg_WB ? load data : ALU result.
- wb_we = regwrite_WB AND (wb_rd != 0). Writes to x0 are suppressed.

Latency and outputs:
- ID to WB: 3 register stages.
- mem_we_MEM and mem_re_MEM are the registered memwrite and memread flags; they are 0 for bubbles.

Simultaneous events:
- Flush and EN asserted together gives a bubble.
- A stall with flush (load-use) on ID/EX and EX/MEM inserts exactly one bubble per flushed cycle; upstream values are held by the core's IF/ID stage.

Test Plan:
1. Reset: drive arbitrary inputs, assert rst for 2 cycles -> all outputs 0, wb_we 0; then release.
2. EX forward: rs1_data_ID=0x11, alu_out_EXE=0xAAAA0001, forward_ctrl_A=01 -> rs1_fwd_ID=0xAAAA0001; after one edge with reg_DE_EN=1, rs1_EXE=0xAAAA0001.
3. MEM/load forward: latch alu_out_MEM=0x100, drive mem_rdata_MEM=0xDEADBEEF, sweep forward_ctrl_B 00/10/11 -> rs2_fwd_ID = rs2_data_ID / 0x100 / 0xDEADBEEF.
4. Load-use bubble: reg_DE_flush=1 with regwrite_ID=1, rd_ID=5 -> next cycle rd_EXE=0 and control flags 0; two cycles later wb_we=0.
5. Load-to-store: load x6 (mem_rdata_MEM=0x12345678) in MEM while store in EX with forward_ctrl_ls=1 and rs2 data 0x0 -> next cycle mem_we_MEM=1, mem_wdata_MEM=0x12345678.
6. Hold and x0: reg_MW_EN=0 for 2 cycles -> wb_* unchanged; an instruction with rd=0, regwrite=1 reaching WB -> wb_we=0.
